// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: immediate-type encoding and width shared by imm_encoder and the Extender
package imm_encoder_pkg;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {
      ITypeImm = 2'd0,
      STypeImm = 2'd1,
      BTypeImm = 2'd2,
      UTypeImm = 2'd3
   } imm_type_e;
endpackage

// File: rtl/imm_skid_buffer.sv
// imm_skid_buffer: generic 2-entry valid/ready pipeline stage (output register + skid register)
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream.
// in_ready is registered and high exactly when the skid entry is empty.
module imm_skid_buffer #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   logic         skid_valid;
   logic [W-1:0] skid_data;
   logic         acc;
   logic         load;
   assign acc  = in_valid & in_ready;
   assign load = ~out_valid | out_ready;
   // A full skid forces in_ready low, so acc and skid_valid are never both set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         in_ready   <= 1'b0;
      end else begin
         if (load) begin
            out_valid  <= skid_valid | acc;
            out_data   <= skid_valid ? skid_data : acc ? in_data : out_data;
            skid_valid <= 1'b0;
         end else if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
         in_ready <= load | ~(skid_valid | acc);
      end
   end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: inserts an immediate into the I/S/B/U fields of a template instruction (inverse of the Extender)
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_inst/in_imm/in_imm_type upstream;
// out_valid/out_ready/out_inst/out_err downstream; enc_count counts accepted inputs.
// Macro IMM_ENCODER_RANGE_CHECK_EN enables the out_err range check; otherwise out_err is 0.
module imm_encoder #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_inst,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [1:0]       in_imm_type,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_inst,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count
);
   import imm_encoder_pkg::*;
   function automatic logic [XLEN-1:0] encode(logic [XLEN-1:0] inst, logic [XLEN-1:0] imm, imm_type_e t);
      return t == ITypeImm ? {imm[11:0], inst[19:0]} :
             t == STypeImm ? {imm[11:5], inst[24:12], imm[4:0], inst[6:0]} :
             t == BTypeImm ? {imm[12], imm[10:5], inst[24:12], imm[4:1], imm[11], inst[6:0]} :
                             {imm[31:12], inst[11:0]};
   endfunction
   imm_type_e       t;
   logic            err;
   logic [XLEN-1:0] enc;
   logic [XLEN:0]   q;
   assign t   = imm_type_e'(in_imm_type);
   assign enc = encode(in_inst, in_imm, t);
`ifdef IMM_ENCODER_RANGE_CHECK_EN
   // Fits when the bits above the field's sign bit are a pure sign extension.
   assign err = t == UTypeImm ? |in_imm[11:0] :
                t == BTypeImm ? ~(&in_imm[31:12] | ~|in_imm[31:12]) | in_imm[0] :
                                ~(&in_imm[31:11] | ~|in_imm[31:11]);
`else
   assign err = 1'b0;
`endif
   imm_skid_buffer #(.W(XLEN + 1)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  ({err, enc}),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (q)
   );
   assign {out_err, out_inst} = q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) enc_count <= '0;
      else if (in_valid && in_ready) enc_count <= enc_count + 1'b1;
   end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder with directed vectors and randomized traffic
module tb_imm_encoder;
`ifdef IMM_ENCODER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic [31:0] in_inst = 0, in_imm = 0;
   logic [1:0]  in_imm_type = 0;
   logic        in_ready, out_valid, out_err;
   logic [31:0] out_inst;
   logic [15:0] enc_count;
   int total = 0, bad = 0, sent = 0;
   bit done = 0;
   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic [31:0] imm;
      logic [1:0]  t;
      bit          fits;
   } item_t;
   item_t q[$];
   always #5 clk = ~clk;
   imm_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_imm(in_imm), .in_imm_type(in_imm_type),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_err(out_err), .enc_count(enc_count)
   );
   function automatic bit fits(logic [31:0] imm, logic [1:0] t);
      int s = imm;
      case (t)
         2'd0, 2'd1: return s >= -2048 && s <= 2047;
         2'd2:       return s >= -4096 && s <= 4095 && (imm & 32'd1) == 0;
         default:    return (imm & 32'hFFF) == 0;
      endcase
   endfunction
   function automatic logic [31:0] model_enc(logic [31:0] inst, logic [31:0] imm, logic [1:0] t);
      case (t)
         2'd0: return (inst & 32'h000FFFFF) | (imm << 20);
         2'd1: return (inst & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
         2'd2: return (inst & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
         default: return (inst & 32'h00000FFF) | (imm & 32'hFFFFF000);
      endcase
   endfunction
   function automatic logic [31:0] extend(logic [31:0] w, logic [1:0] t);
      int s = w;
      int hi20 = s >>> 20;
      int hi25 = s >>> 25;
      int hi31 = s >>> 31;
      case (t)
         2'd0: return hi20;
         2'd1: return (hi25 << 5) | ((w >> 7) & 32'h1F);
         2'd2: return (hi31 << 12) | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
         default: return w & 32'hFFFFF000;
      endcase
   endfunction
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask
   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(logic [31:0] i, logic [31:0] m, logic [1:0] t);
      bit acc = 0;
      item_t it;
      in_valid = 1; in_inst = i; in_imm = m; in_imm_type = t;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         if (acc) begin
            it.inst = model_enc(i, m, t);
            it.fits = fits(m, t);
            it.err  = RC && !it.fits;
            it.imm  = m;
            it.t    = t;
            q.push_back(it);
            sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 0;
      if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
   endtask
   task automatic drain();
      for (int n = 0; n < 300 && q.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain_empty", q.size(), 0);
   endtask
   logic [31:0] held;
   bit stalled = 0;
   always @(negedge clk) begin
      item_t it;
      if (rst) stalled = 0;
      else begin
         if (stalled) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_inst", out_inst, held);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_word: got %h want none", out_inst);
            end else begin
               it = q.pop_front();
               chk("out_inst", out_inst, it.inst);
               chk("out_err", {31'd0, out_err}, {31'd0, it.err});
               if (it.fits) chk("round_trip", extend(out_inst, it.t), it.imm);
            end
         end
         stalled = out_valid && !out_ready;
         held = out_inst;
      end
   end
   logic [31:0] d_inst[5] = '{32'h00000093, 32'h00112023, 32'h00000063, 32'h00000037, 32'h00000037};
   logic [31:0] d_imm[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h12345000, 32'h12345001};
   logic [1:0]  d_t[5]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
   logic [31:0] d_exp[5]  = '{32'hFFF00093, 32'hFE112E23, 32'h000000E3, 32'h12345037, 32'h12345037};
   logic        d_err[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, RC};
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      chk("rst_out_inst", out_inst, 0);
      chk("rst_out_err", {31'd0, out_err}, 0);
      chk("rst_count", {16'd0, enc_count}, 0);
      @(posedge clk); #1;
      rst = 0; out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         send(d_inst[i], d_imm[i], d_t[i]);
         @(negedge clk);
         chk("dir_latency", {31'd0, out_valid}, 1);
         chk("dir_inst", out_inst, d_exp[i]);
         chk("dir_err", {31'd0, out_err}, {31'd0, d_err[i]});
         if (i == 0) chk("dir_count", {16'd0, enc_count}, 1);
         @(posedge clk); #1;
      end
      out_ready = 0;
      send(32'h00000013, 32'h00000123, 2'd0);
      send(32'h00000023, 32'h00000045, 2'd1);
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_count", {16'd0, enc_count}, 32'(16'(sent)));
      @(posedge clk); #1;
      fork
         send(32'h00000063, 32'hFFFFFFF0, 2'd2);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();
      chk("bp_count_after", {16'd0, enc_count}, 32'(16'(sent)));
      @(posedge clk); #1;
      out_ready = 0;
      send(32'h00000093, 32'h00000001, 2'd0);
      send(32'h00000037, 32'hABCDE000, 2'd3);
      @(negedge clk); #2;
      rst = 1;
      #1;
      q.delete();
      sent = 0;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_count", {16'd0, enc_count}, 0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
      chk("mid_rst_out_inst", out_inst, 0);
      @(posedge clk); @(negedge clk); @(posedge clk); #1;
      rst = 0; out_ready = 1;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 1);
      chk("post_rst_out_valid", {31'd0, out_valid}, 0);
      repeat (4) @(posedge clk);
      #1;
      fork
         begin
            for (int n = 0; n < 400; n++) begin
               logic [31:0] m;
               int v;
               case ($urandom_range(0, 3))
                  0: m = $urandom;
                  1: begin v = $urandom_range(0, 4095); m = v - 2048; end
                  2: m = $urandom & 32'hFFFFF000;
                  default: begin v = $urandom_range(0, 8191); m = (v - 4096) & ~32'd1; end
               endcase
               send($urandom, m, 2'($urandom_range(0, 3)));
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            done = 1;
         end
         while (!done) begin
            @(posedge clk); #1;
            out_ready = $urandom_range(0, 3) != 0;
         end
      join
      out_ready = 1;
      drain();
      chk("final_count", {16'd0, enc_count}, 32'(16'(sent)));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
